cfu_cmd_initiator: RTL and testbench
====================================

CFU_CMD_INITIATOR -- requirements
Module: cfu_cmd_initiator

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4: number of queued commands (power of two, at least 2).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 1024: maximum wait for a CFU response, in cycles.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, named as in the codebase:
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  1  upstream command present.
REQ-007 req_ready  output  1  command queue can accept.
REQ-008 req_function_id  input  10  {func7, func3} of the command.
REQ-009 req_inputs_0  input  32  first operand.
REQ-010 req_inputs_1  input  32  second operand.
REQ-011 cmd_valid  output  1  command offered to the CFU.
REQ-012 cmd_ready  input  1  CFU accepts the command.
REQ-013 cmd_payload_function_id  output  10  function id presented to the CFU.
REQ-014 cmd_payload_inputs_0  output  32  operand 0 presented to the CFU.
REQ-015 cmd_payload_inputs_1  output  32  operand 1 presented to the CFU.
REQ-016 rsp_valid  input  1  CFU response present.
REQ-017 rsp_ready  output  1  initiator accepts the response.
REQ-018 rsp_payload_outputs_0  input  32  CFU result.
REQ-019 res_valid  output  1  result available upstream.
REQ-020 res_ready  input  1  upstream consumes the result.
REQ-021 res_data  output  32  captured result.
REQ-022 res_timeout  output  1  this result was produced by a timeout, not by the CFU.
REQ-023 busy  output  1  FSM not in IDLE, or queue not empty.
REQ-024 issued_count  output  16  number of cmd handshakes, wrapping.

Function
REQ-025 Queue: FIFO_DEPTH-entry FIFO of {function_id, inputs_0, inputs_1}; req_ready = !full; push on req_valid && req_ready; no bypass when full, even if the FSM pops in the same cycle.
REQ-026 Pointers SHALL wrap modulo FIFO_DEPTH; full/empty SHALL be tracked with an extra pointer bit or an occupancy count.
REQ-027 FSM states SHALL be IDLE, ISSUE, WAIT_RSP and DELIVER.
REQ-028 IDLE: if the queue is not empty, the FSM SHALL pop the head into the cmd_payload registers and go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-029 ISSUE: cmd_valid SHALL be 1 with the payload held stable until cmd_ready; on cmd_valid && cmd_ready the FSM SHALL go to WAIT_RSP, increment issued_count and clear the timeout counter.
REQ-030 ISSUE has no timeout; cmd_ready may stay low indefinitely (for example, while the CFU is busy accumulating).
REQ-031 WAIT_RSP: rsp_ready SHALL be 1; on rsp_valid the FSM SHALL capture rsp_payload_outputs_0 into res_data, set res_timeout=0 and go to DELIVER.
REQ-032 WAIT_RSP: the counter SHALL increment each cycle without rsp_valid; when it reaches TIMEOUT_CYCLES-1, the FSM SHALL load res_data=32'hDEAD_BEEF, set res_timeout=1 and go to DELIVER.
REQ-033 If rsp_valid and the timeout threshold occur in the same cycle, the response SHALL win.
REQ-034 rsp_ready SHALL be 0 in every state other than WAIT_RSP; only one command SHALL be outstanding at a time.
REQ-035 DELIVER: res_valid SHALL be 1 with res_data and res_timeout stable until res_ready; on the handshake the FSM SHALL go to IDLE.
REQ-036 Latency, when idle with an empty queue: req handshake in cycle N gives cmd_valid=1 in cycle N+2; rsp handshake in cycle M gives res_valid=1 in cycle M+1.
REQ-037 Back-to-back throughput SHALL be at most one command per 4 cycles: IDLE, ISSUE, WAIT_RSP and DELIVER, each taking at least one cycle.
REQ-038 issued_count SHALL wrap from 16'hFFFF to 0.

Reset
REQ-039 On reset assertion, asynchronously: FSM to IDLE; FIFO emptied; cmd_valid, rsp_ready, res_valid and res_timeout set to 0; res_data, the cmd_payload registers, issued_count and the timeout counter set to 0.
REQ-040 Reset asserted mid-operation SHALL abandon any in-flight command with no handshake completed, and SHALL drop all queued commands.
REQ-041 req_ready SHALL read 1 in the first cycle after reset release.

Verification
REQ-042 Single command: push {id=10'h008, 5, 7}; CFU accepts immediately and answers 32'h0000_0023 one cycle later -> cmd_valid in cycle N+2, res_data=32'h23, res_timeout=0, issued_count=1.
REQ-043 Stall: cmd_ready held low for 50 cycles -> cmd_valid stays 1 with an unchanged payload, no timeout, and the command issues when cmd_ready rises.
REQ-044 Fill: push 5 commands with res_ready=0 -> req_ready drops after the 4th push plus the popped entry; with one command in flight, all commands are eventually issued in FIFO order.
REQ-045 Timeout: rsp_valid never asserted -> res_valid, res_data=32'hDEAD_BEEF and res_timeout=1 after TIMEOUT_CYCLES cycles in WAIT_RSP; a simultaneous rsp_valid on the final cycle yields the real data instead.
REQ-046 Reset while in WAIT_RSP with 3 commands queued -> all outputs take their reset values immediately, and the queue is empty after release.
REQ-047 Wrap: issue 65537 commands -> issued_count=1.

Source files
------------

// File: rtl/cfu_cmd_initiator_if.sv
// Handshake bundle between upstream, the command initiator and the CFU.
// The initiator drives through "master"; the surrounding environment uses "slave".
interface cfu_cmd_initiator_if;
   logic        req_valid;
   logic        req_ready;
   logic [9:0]  req_function_id;
   logic [31:0] req_inputs_0;
   logic [31:0] req_inputs_1;

   logic        cmd_valid;
   logic        cmd_ready;
   logic [9:0]  cmd_payload_function_id;
   logic [31:0] cmd_payload_inputs_0;
   logic [31:0] cmd_payload_inputs_1;

   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_payload_outputs_0;

   logic        res_valid;
   logic        res_ready;
   logic [31:0] res_data;
   logic        res_timeout;

   logic        busy;
   logic [15:0] issued_count;

   modport master (
      input  req_valid, req_function_id, req_inputs_0, req_inputs_1,
      input  cmd_ready, rsp_valid, rsp_payload_outputs_0, res_ready,
      output req_ready, cmd_valid, cmd_payload_function_id,
      output cmd_payload_inputs_0, cmd_payload_inputs_1,
      output rsp_ready, res_valid, res_data, res_timeout, busy, issued_count
   );

   modport slave (
      output req_valid, req_function_id, req_inputs_0, req_inputs_1,
      output cmd_ready, rsp_valid, rsp_payload_outputs_0, res_ready,
      input  req_ready, cmd_valid, cmd_payload_function_id,
      input  cmd_payload_inputs_0, cmd_payload_inputs_1,
      input  rsp_ready, res_valid, res_data, res_timeout, busy, issued_count
   );
endinterface

// File: rtl/cfu_cmd_initiator.sv
// Queues upstream CFU commands, issues them one at a time and hands the CFU
// result (or a timeout marker) back upstream.
module cfu_cmd_initiator #(
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input logic                 clk,
   input logic                 reset,
   cfu_cmd_initiator_if.master bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [AW:0]   DEPTH    = (AW+1)'(FIFO_DEPTH);

   typedef struct packed {
      logic [9:0]  fid;
      logic [31:0] in0;
      logic [31:0] in1;
   } cmd_t;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, DELIVER} state_t;

   state_t        state_q, state_d;
   cmd_t          mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q;
   cmd_t          cmd_q, cmd_d;
   logic [31:0]   res_data_q, res_data_d;
   logic          res_tmo_q, res_tmo_d;
   logic [15:0]   issued_q, issued_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          full, empty, push, pop;

   assign full  = (count_q == DEPTH);
   assign empty = (count_q == '0);
   // No bypass: a full queue refuses a push even when the FSM pops this cycle.
   assign push  = bus.req_valid && !full;
   assign pop   = (state_q == IDLE) && !empty;

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= '{fid: bus.req_function_id,
                                     in0: bus.req_inputs_0,
                                     in1: bus.req_inputs_1};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         if (push && !pop)      count_q <= count_q + (AW+1)'(1);
         else if (!push && pop) count_q <= count_q - (AW+1)'(1);
      end
   end

   always_comb begin
      state_d    = state_q;
      cmd_d      = cmd_q;
      res_data_d = res_data_q;
      res_tmo_d  = res_tmo_q;
      issued_d   = issued_q;
      tmo_d      = tmo_q;
      case (state_q)
         IDLE: begin
            if (!empty) begin
               cmd_d   = mem_q[rd_ptr_q];
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (bus.cmd_ready) begin
               issued_d = issued_q + 16'd1;
               tmo_d    = '0;
               state_d  = WAIT_RSP;
            end
         end
         WAIT_RSP: begin
            // A response arriving on the threshold cycle beats the timeout.
            if (bus.rsp_valid) begin
               res_data_d = bus.rsp_payload_outputs_0;
               res_tmo_d  = 1'b0;
               state_d    = DELIVER;
            end else if (tmo_q == TMO_LAST) begin
               res_data_d = 32'hDEAD_BEEF;
               res_tmo_d  = 1'b1;
               state_d    = DELIVER;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         DELIVER: begin
            if (bus.res_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         cmd_q      <= '0;
         res_data_q <= '0;
         res_tmo_q  <= 1'b0;
         issued_q   <= '0;
         tmo_q      <= '0;
      end else begin
         state_q    <= state_d;
         cmd_q      <= cmd_d;
         res_data_q <= res_data_d;
         res_tmo_q  <= res_tmo_d;
         issued_q   <= issued_d;
         tmo_q      <= tmo_d;
      end
   end

   assign bus.req_ready               = !full;
   assign bus.cmd_valid               = (state_q == ISSUE);
   assign bus.cmd_payload_function_id = cmd_q.fid;
   assign bus.cmd_payload_inputs_0    = cmd_q.in0;
   assign bus.cmd_payload_inputs_1    = cmd_q.in1;
   assign bus.rsp_ready               = (state_q == WAIT_RSP);
   assign bus.res_valid               = (state_q == DELIVER);
   assign bus.res_data                = res_data_q;
   assign bus.res_timeout             = res_tmo_q;
   assign bus.busy                    = (state_q != IDLE) || !empty;
   assign bus.issued_count            = issued_q;
endmodule

// File: tb/tb_cfu_cmd_initiator.sv
// Randomized and directed bench for cfu_cmd_initiator, with a transaction-level
// reference (ordered command queue, CFU result function, handshake spacing).
module tb_cfu_cmd_initiator;
   localparam int DEPTH = 4;
   localparam int TMO   = 64;

   typedef struct packed {
      logic [9:0]  fid;
      logic [31:0] in0;
      logic [31:0] in1;
   } cmd_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   cfu_cmd_initiator_if bus();

   cfu_cmd_initiator #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   // CFU / result-sink side: either the random agent or the directed tests drive it.
   logic        cfu_auto = 1'b0;
   int          cmd_pct = 100, res_pct = 100, rsp_max = 0;
   logic        a_cmd_ready = 1'b0, a_rsp_valid = 1'b0, a_res_ready = 1'b0;
   logic [31:0] a_rsp_data = '0;
   logic        m_cmd_ready = 1'b0, m_rsp_valid = 1'b0, m_res_ready = 1'b0;
   logic [31:0] m_rsp_data = '0;

   assign bus.cmd_ready             = cfu_auto ? a_cmd_ready : m_cmd_ready;
   assign bus.rsp_valid             = cfu_auto ? a_rsp_valid : m_rsp_valid;
   assign bus.rsp_payload_outputs_0 = cfu_auto ? a_rsp_data  : m_rsp_data;
   assign bus.res_ready             = cfu_auto ? a_res_ready : m_res_ready;

   // Transaction logs, only ever appended by the monitor.
   cmd_t        pushed_q[$];
   cmd_t        issued_log[$];
   logic [32:0] res_log[$];
   int          cmd_cyc[$];
   int          cyc = 0, issued_m = 0, phase = 0, rsp_dly = 0;
   int          lat_err = 0, stray = 0, ovl = 0;
   logic        exp_res = 1'b0;
   cmd_t        inflight = '0;

   function automatic logic [31:0] cfu_fn(input cmd_t c);
      return (c.in0 + c.in1) ^ {22'd0, c.fid};
   endfunction

   function automatic cmd_t rand_cmd();
      cmd_t c;
      c.fid = 10'($urandom_range(1023));
      c.in0 = $urandom;
      c.in1 = $urandom;
      return c;
   endfunction

   function automatic cmd_t cur_payload();
      return {bus.cmd_payload_function_id, bus.cmd_payload_inputs_0, bus.cmd_payload_inputs_1};
   endfunction

   task automatic drive_req(input cmd_t c);
      bus.req_valid       = 1'b1;
      bus.req_function_id = c.fid;
      bus.req_inputs_0    = c.in0;
      bus.req_inputs_1    = c.in1;
   endtask

   // Agent drives at the falling edge; monitor observes settled values 2ns later.
   always begin
      @(negedge clk);
      a_cmd_ready = ($urandom_range(99) < cmd_pct);
      a_res_ready = ($urandom_range(99) < res_pct);
      a_rsp_valid = 1'b0;
      if (phase == 1 && bus.rsp_ready) begin
         if (rsp_dly > 0) rsp_dly--;
         else begin
            a_rsp_valid = 1'b1;
            a_rsp_data  = cfu_fn(inflight);
         end
      end
      #2;
      cyc++;
      if (reset) begin
         phase = 0; issued_m = 0; exp_res = 1'b0;
      end else begin
         if (exp_res && !bus.res_valid) lat_err++;
         exp_res = 1'b0;
         if (bus.rsp_ready && phase != 1) stray++;
         if (bus.req_valid && bus.req_ready)
            pushed_q.push_back({bus.req_function_id, bus.req_inputs_0, bus.req_inputs_1});
         if (bus.cmd_valid && bus.cmd_ready) begin
            if (phase != 0) ovl++;
            inflight = cur_payload();
            issued_log.push_back(inflight);
            cmd_cyc.push_back(cyc);
            issued_m++;
            phase   = 1;
            rsp_dly = $urandom_range(rsp_max);
         end
         if (bus.rsp_valid && bus.rsp_ready) begin
            phase = 2; exp_res = 1'b1;
         end
         if (bus.res_valid && bus.res_ready) begin
            res_log.push_back({bus.res_timeout, bus.res_data});
            phase = 0;
         end
      end
   end

   task automatic test_reset();
      bus.req_valid = 1'b0; bus.req_function_id = '0; bus.req_inputs_0 = '0; bus.req_inputs_1 = '0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      tests++;
      if ({bus.cmd_valid, bus.rsp_ready, bus.res_valid, bus.res_timeout, bus.busy} !== 5'b0) begin
         fails++;
         $display("FAIL reset_ctrl: got cv/rr/resv/tmo/busy=%b, want 00000",
                  {bus.cmd_valid, bus.rsp_ready, bus.res_valid, bus.res_timeout, bus.busy});
      end
      tests++;
      if (bus.issued_count !== 16'd0 || bus.res_data !== 32'd0 || cur_payload() !== '0) begin
         fails++;
         $display("FAIL reset_data: got cnt=%h res=%h pay=%h, want zeros",
                  bus.issued_count, bus.res_data, cur_payload());
      end
      reset = 1'b0;
      @(negedge clk);
      tests++;
      if (bus.req_ready !== 1'b1) begin
         fails++; $display("FAIL reset_req_ready: got %b, want 1", bus.req_ready);
      end
   endtask

   task automatic test_single();
      cmd_t c;
      c = '{fid: 10'h008, in0: 32'd5, in1: 32'd7};
      cfu_auto = 1'b0;
      @(negedge clk);
      drive_req(c);
      tests++;
      if (bus.req_ready !== 1'b1) begin
         fails++; $display("FAIL single_accept: req_ready=%b, want 1", bus.req_ready);
      end
      @(negedge clk);
      bus.req_valid = 1'b0;
      tests++;
      if (bus.cmd_valid !== 1'b0) begin
         fails++; $display("FAIL single_lat_n1: cmd_valid=%b in N+1, want 0", bus.cmd_valid);
      end
      @(negedge clk);
      tests++;
      if (bus.cmd_valid !== 1'b1 || cur_payload() !== c) begin
         fails++; $display("FAIL single_lat_n2: cmd_valid=%b pay=%h, want 1 %h", bus.cmd_valid, cur_payload(), c);
      end
      m_cmd_ready = 1'b1;
      @(negedge clk);
      m_cmd_ready = 1'b0;
      m_rsp_valid = 1'b1; m_rsp_data = 32'h0000_0023;
      @(negedge clk);
      m_rsp_valid = 1'b0;
      tests++;
      if (bus.res_valid !== 1'b1 || bus.res_data !== 32'h23 || bus.res_timeout !== 1'b0) begin
         fails++;
         $display("FAIL single_result: got v=%b data=%h tmo=%b, want 1 00000023 0",
                  bus.res_valid, bus.res_data, bus.res_timeout);
      end
      tests++;
      if (bus.issued_count !== 16'd1) begin
         fails++; $display("FAIL single_count: got %0d, want 1", bus.issued_count);
      end
      m_res_ready = 1'b1;
      @(negedge clk);
      m_res_ready = 1'b0;
      tests++;
      if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
         fails++; $display("FAIL single_done: res_valid=%b busy=%b, want 0 0", bus.res_valid, bus.busy);
      end
   endtask

   task automatic test_stall();
      cmd_t c;
      int   k, bad;
      c = rand_cmd();
      cfu_auto = 1'b0;
      @(negedge clk); drive_req(c);
      @(negedge clk); bus.req_valid = 1'b0;
      k = 0;
      while (bus.cmd_valid !== 1'b1 && k < 5) begin @(negedge clk); k++; end
      tests++;
      if (bus.cmd_valid !== 1'b1) begin
         fails++; $display("FAIL stall_offer: cmd_valid=%b after %0d cycles, want 1", bus.cmd_valid, k);
      end
      bad = 0;
      repeat (50) begin
         @(negedge clk);
         if (bus.cmd_valid !== 1'b1 || cur_payload() !== c || bus.res_valid !== 1'b0) bad++;
      end
      tests++;
      if (bad != 0) begin
         fails++; $display("FAIL stall_hold: %0d unstable cycles, want 0", bad);
      end
      m_cmd_ready = 1'b1;
      @(negedge clk);
      m_cmd_ready = 1'b0;
      tests++;
      if (bus.rsp_ready !== 1'b1 || bus.cmd_valid !== 1'b0) begin
         fails++; $display("FAIL stall_issue: rsp_ready=%b cmd_valid=%b, want 1 0", bus.rsp_ready, bus.cmd_valid);
      end
      repeat (3) @(negedge clk);
      m_rsp_valid = 1'b1; m_rsp_data = cfu_fn(c);
      @(negedge clk);
      m_rsp_valid = 1'b0;
      tests++;
      if (bus.res_valid !== 1'b1 || bus.res_data !== cfu_fn(c) || bus.res_timeout !== 1'b0) begin
         fails++;
         $display("FAIL stall_result: got v=%b data=%h tmo=%b, want 1 %h 0",
                  bus.res_valid, bus.res_data, bus.res_timeout, cfu_fn(c));
      end
      m_res_ready = 1'b1;
      @(negedge clk);
      m_res_ready = 1'b0;
   endtask

   task automatic test_fill();
      cmd_t cs[5];
      int   i0, r0, bad, k;
      cfu_auto = 1'b1; cmd_pct = 100; res_pct = 0; rsp_max = 0;
      i0 = issued_log.size(); r0 = res_log.size();
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         cs[i] = rand_cmd();
         drive_req(cs[i]);
         if (bus.req_ready !== 1'b1) bad++;
      end
      tests++;
      if (bad != 0) begin
         fails++; $display("FAIL fill_accept: %0d of 5 pushes refused, want 0", bad);
      end
      @(negedge clk);
      drive_req(rand_cmd());
      tests++;
      if (bus.req_ready !== 1'b0) begin
         fails++; $display("FAIL fill_full: req_ready=%b after 5 pushes, want 0", bus.req_ready);
      end
      repeat (3) @(negedge clk);
      tests++;
      if (bus.req_ready !== 1'b0) begin
         fails++; $display("FAIL fill_hold: req_ready=%b while result blocked, want 0", bus.req_ready);
      end
      bus.req_valid = 1'b0;
      res_pct = 100;
      k = 0;
      while ((res_log.size() - r0 < 5 || bus.busy) && k < 200) begin @(negedge clk); k++; end
      tests++;
      if (issued_log.size() - i0 != 5 || res_log.size() - r0 != 5) begin
         fails++;
         $display("FAIL fill_count: issued=%0d results=%0d, want 5 5", issued_log.size() - i0, res_log.size() - r0);
      end else begin
         bad = 0;
         for (int i = 0; i < 5; i++)
            if (issued_log[i0+i] !== cs[i] || res_log[r0+i] !== {1'b0, cfu_fn(cs[i])}) bad++;
         if (bad != 0) begin
            fails++; $display("FAIL fill_order: %0d entries out of order or wrong, want 0", bad);
         end
      end
   endtask

   task automatic test_timeout();
      cmd_t        c;
      int          w, k;
      logic [31:0] d, want_d;
      cfu_auto = 1'b0;
      for (int mode = 0; mode < 2; mode++) begin
         c = rand_cmd();
         d = $urandom;
         @(negedge clk); drive_req(c);
         @(negedge clk); bus.req_valid = 1'b0;
         @(negedge clk); m_cmd_ready = 1'b1;
         @(negedge clk); m_cmd_ready = 1'b0;
         w = 0; k = 0;
         while (bus.rsp_ready === 1'b1 && k < TMO + 10) begin
            w++;
            if (mode == 1 && w == TMO) begin m_rsp_valid = 1'b1; m_rsp_data = d; end
            @(negedge clk);
            m_rsp_valid = 1'b0;
            k++;
         end
         want_d = (mode == 1) ? d : 32'hDEAD_BEEF;
         tests++;
         if (w != TMO) begin
            fails++; $display("FAIL timeout_len%0d: %0d cycles in WAIT_RSP, want %0d", mode, w, TMO);
         end
         tests++;
         if (bus.res_valid !== 1'b1 || bus.res_data !== want_d || bus.res_timeout !== (mode == 0)) begin
            fails++;
            $display("FAIL timeout_res%0d: got v=%b data=%h tmo=%b, want 1 %h %b",
                     mode, bus.res_valid, bus.res_data, bus.res_timeout, want_d, mode == 0);
         end
         m_res_ready = 1'b1;
         @(negedge clk);
         m_res_ready = 1'b0;
      end
   endtask

   task automatic test_reset_mid();
      int bad;
      cfu_auto = 1'b0;
      m_cmd_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin @(negedge clk); drive_req(rand_cmd()); end
      @(negedge clk);
      bus.req_valid = 1'b0; m_cmd_ready = 1'b0;
      tests++;
      if (bus.rsp_ready !== 1'b1 || bus.busy !== 1'b1) begin
         fails++; $display("FAIL rmid_setup: rsp_ready=%b busy=%b, want 1 1", bus.rsp_ready, bus.busy);
      end
      #1 reset = 1'b1;
      #1;
      tests++;
      if ({bus.cmd_valid, bus.rsp_ready, bus.res_valid, bus.res_timeout, bus.busy} !== 5'b0 ||
          bus.req_ready !== 1'b1) begin
         fails++;
         $display("FAIL rmid_ctrl: got cv/rr/resv/tmo/busy=%b req_ready=%b, want 00000 1",
                  {bus.cmd_valid, bus.rsp_ready, bus.res_valid, bus.res_timeout, bus.busy}, bus.req_ready);
      end
      tests++;
      if (cur_payload() !== '0 || bus.res_data !== 32'd0 || bus.issued_count !== 16'd0) begin
         fails++;
         $display("FAIL rmid_data: pay=%h res=%h cnt=%h, want zeros", cur_payload(), bus.res_data, bus.issued_count);
      end
      @(negedge clk);
      reset = 1'b0;
      bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (bus.cmd_valid !== 1'b0 || bus.busy !== 1'b0 || bus.req_ready !== 1'b1) bad++;
      end
      tests++;
      if (bad != 0) begin
         fails++; $display("FAIL rmid_empty: %0d cycles with leftover work, want 0", bad);
      end
   endtask

   task automatic test_random();
      int p0, i0, r0, c0, n, k, bad, lat0, str0, ovl0;
      cfu_auto = 1'b1; cmd_pct = 60; res_pct = 60; rsp_max = 6;
      p0 = pushed_q.size(); i0 = issued_log.size(); r0 = res_log.size(); c0 = cmd_cyc.size();
      lat0 = lat_err; str0 = stray; ovl0 = ovl;
      repeat (600) begin
         @(negedge clk);
         if ($urandom_range(1) == 1) drive_req(rand_cmd());
         else bus.req_valid = 1'b0;
      end
      @(negedge clk);
      bus.req_valid = 1'b0;
      k = 0;
      while ((res_log.size() - r0 < pushed_q.size() - p0 || bus.busy) && k < 1000) begin
         @(negedge clk); k++;
      end
      n = pushed_q.size() - p0;
      tests++;
      if (n < 20 || issued_log.size() - i0 != n || res_log.size() - r0 != n) begin
         fails++;
         $display("FAIL rand_count: pushed=%0d issued=%0d results=%0d, want equal and >=20",
                  n, issued_log.size() - i0, res_log.size() - r0);
      end else begin
         bad = 0;
         for (int i = 0; i < n; i++) if (issued_log[i0+i] !== pushed_q[p0+i]) bad++;
         tests++;
         if (bad != 0) begin
            fails++; $display("FAIL rand_order: %0d of %0d commands out of order, want 0", bad, n);
         end
         bad = 0;
         for (int i = 0; i < n; i++) if (res_log[r0+i] !== {1'b0, cfu_fn(pushed_q[p0+i])}) bad++;
         tests++;
         if (bad != 0) begin
            fails++; $display("FAIL rand_results: %0d of %0d results wrong, want 0", bad, n);
         end
      end
      bad = 0;
      for (int i = c0 + 1; i < cmd_cyc.size(); i++) if (cmd_cyc[i] - cmd_cyc[i-1] < 4) bad++;
      tests++;
      if (bad != 0) begin
         fails++; $display("FAIL rand_spacing: %0d issues closer than 4 cycles, want 0", bad);
      end
      tests++;
      if (lat_err != lat0 || stray != str0 || ovl != ovl0) begin
         fails++;
         $display("FAIL rand_protocol: latency=%0d stray_rsp_ready=%0d overlap=%0d, want 0 0 0",
                  lat_err - lat0, stray - str0, ovl - ovl0);
      end
      tests++;
      if (bus.issued_count !== 16'(issued_m)) begin
         fails++; $display("FAIL rand_issued: got %0d, want %0d", bus.issued_count, 16'(issued_m));
      end
   endtask

   task automatic test_wrap();
      logic [15:0] want;
      int          r0, k;
      cfu_auto = 1'b1; cmd_pct = 100; res_pct = 100; rsp_max = 0;
      @(negedge clk);
      force dut.issued_q = 16'hFFFE;
      @(negedge clk);
      release dut.issued_q;
      @(negedge clk);
      tests++;
      if (bus.issued_count !== 16'hFFFE) begin
         fails++; $display("FAIL wrap_preset: got %h, want fffe", bus.issued_count);
      end
      want = 16'hFFFE;
      for (int i = 0; i < 3; i++) begin
         r0 = res_log.size();
         @(negedge clk); drive_req(rand_cmd());
         @(negedge clk); bus.req_valid = 1'b0;
         k = 0;
         while ((res_log.size() == r0 || bus.busy) && k < 50) begin @(negedge clk); k++; end
         want = want + 16'd1;
         tests++;
         if (bus.issued_count !== want) begin
            fails++; $display("FAIL wrap_step%0d: got %h, want %h", i, bus.issued_count, want);
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_stall();
      test_fill();
      test_timeout();
      test_reset_mid();
      test_random();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
